// File: rtl/display_pkg.sv
// Shared video timing constants: coordinate width and standard mode sets.
package display_pkg;

  localparam int unsigned COORD_W = 16;
  localparam int unsigned TW      = 16;

  typedef struct packed {
    logic [TW-1:0] h_res;
    logic [TW-1:0] h_fp;
    logic [TW-1:0] h_sync;
    logic [TW-1:0] h_bp;
    logic [TW-1:0] v_res;
    logic [TW-1:0] v_fp;
    logic [TW-1:0] v_sync;
    logic [TW-1:0] v_bp;
    logic          h_pol;
    logic          v_pol;
  } timing_t;

  localparam timing_t MODE_640X480_60 = '{
    h_res: TW'(640),  h_fp: TW'(16),  h_sync: TW'(96), h_bp: TW'(48),
    v_res: TW'(480),  v_fp: TW'(10),  v_sync: TW'(2),  v_bp: TW'(33),
    h_pol: 1'b0,      v_pol: 1'b0
  };

  localparam timing_t MODE_1280X720_60 = '{
    h_res: TW'(1280), h_fp: TW'(110), h_sync: TW'(40), h_bp: TW'(220),
    v_res: TW'(720),  v_fp: TW'(5),   v_sync: TW'(5),  v_bp: TW'(20),
    h_pol: 1'b1,      v_pol: 1'b1
  };

endpackage

// File: rtl/signed_wrap_counter.sv
// Signed counter running MIN..MAX; o_wrap flags that the count currently sits at MAX.
module signed_wrap_counter #(
  parameter int unsigned             CORDW = 16,
  parameter logic signed [CORDW-1:0] MIN   = '0,
  parameter logic signed [CORDW-1:0] MAX   = '1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  output logic signed [CORDW-1:0] o_cnt,
  output logic                    o_wrap
);

  logic signed [CORDW-1:0] cnt_next;

  always_comb begin
    cnt_next = o_cnt;
    if (i_en) cnt_next = (o_cnt == MAX) ? MIN : o_cnt + CORDW'(1);
  end

  // o_wrap is registered from the next count so it lines up with o_cnt
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cnt  <= MIN;
      o_wrap <= (MIN == MAX);
    end else begin
      o_cnt  <= cnt_next;
      o_wrap <= (cnt_next == MAX);
    end
  end

endmodule

// File: rtl/display_timings_gen.sv
// Raster scan generator: signed coordinates with negative blanking, syncs, DE and strobes.
module display_timings_gen
  import display_pkg::*;
#(
  parameter int unsigned CORDW  = COORD_W,
  parameter int unsigned H_RES  = 32'(MODE_640X480_60.h_res),
  parameter int unsigned V_RES  = 32'(MODE_640X480_60.v_res),
  parameter int unsigned H_FP   = 32'(MODE_640X480_60.h_fp),
  parameter int unsigned H_SYNC = 32'(MODE_640X480_60.h_sync),
  parameter int unsigned H_BP   = 32'(MODE_640X480_60.h_bp),
  parameter int unsigned V_FP   = 32'(MODE_640X480_60.v_fp),
  parameter int unsigned V_SYNC = 32'(MODE_640X480_60.v_sync),
  parameter int unsigned V_BP   = 32'(MODE_640X480_60.v_bp),
  parameter logic        H_POL  = MODE_640X480_60.h_pol,
  parameter logic        V_POL  = MODE_640X480_60.v_pol
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  output logic                    o_hs,
  output logic                    o_vs,
  output logic                    o_de,
  output logic                    o_frame,
  output logic                    o_line,
  output logic signed [CORDW-1:0] o_sx,
  output logic signed [CORDW-1:0] o_sy
);

  localparam int H_STA_I  = -int'(H_FP + H_SYNC + H_BP);
  localparam int HS_STA_I = H_STA_I + int'(H_FP);
  localparam int HS_END_I = HS_STA_I + int'(H_SYNC);
  localparam int H_END_I  = int'(H_RES) - 1;
  localparam int V_STA_I  = -int'(V_FP + V_SYNC + V_BP);
  localparam int VS_STA_I = V_STA_I + int'(V_FP);
  localparam int VS_END_I = VS_STA_I + int'(V_SYNC);
  localparam int V_END_I  = int'(V_RES) - 1;
  localparam int LIM      = 2 ** (CORDW - 1);

  if (H_STA_I < -LIM || H_END_I >= LIM || V_STA_I < -LIM || V_END_I >= LIM) begin : g_range_err
    $fatal(1, "display_timings_gen: timing range does not fit in CORDW bits");
  end

  localparam logic signed [CORDW-1:0] H_STA  = CORDW'(H_STA_I);
  localparam logic signed [CORDW-1:0] HS_STA = CORDW'(HS_STA_I);
  localparam logic signed [CORDW-1:0] HS_END = CORDW'(HS_END_I);
  localparam logic signed [CORDW-1:0] H_END  = CORDW'(H_END_I);
  localparam logic signed [CORDW-1:0] V_STA  = CORDW'(V_STA_I);
  localparam logic signed [CORDW-1:0] VS_STA = CORDW'(VS_STA_I);
  localparam logic signed [CORDW-1:0] VS_END = CORDW'(VS_END_I);
  localparam logic signed [CORDW-1:0] V_END  = CORDW'(V_END_I);

  logic                    x_wrap;
  logic                    y_wrap;
  logic signed [CORDW-1:0] sx_n;
  logic signed [CORDW-1:0] sy_n;

  signed_wrap_counter #(.CORDW(CORDW), .MIN(H_STA), .MAX(H_END)) u_x (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (1'b1),
    .o_cnt  (o_sx),
    .o_wrap (x_wrap)
  );

  signed_wrap_counter #(.CORDW(CORDW), .MIN(V_STA), .MAX(V_END)) u_y (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (x_wrap),
    .o_cnt  (o_sy),
    .o_wrap (y_wrap)
  );

  // Next-state coordinates, so decoded flags land in the same cycle as o_sx/o_sy
  always_comb begin
    sx_n = x_wrap ? H_STA : o_sx + CORDW'(1);
    sy_n = o_sy;
    if (x_wrap) sy_n = y_wrap ? V_STA : o_sy + CORDW'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_hs    <= ~H_POL;
      o_vs    <= ~V_POL;
      o_de    <= 1'b0;
      o_line  <= 1'b0;
      o_frame <= 1'b0;
    end else begin
      o_hs    <= (sx_n >= HS_STA && sx_n < HS_END) ? H_POL : ~H_POL;
      o_vs    <= (sy_n >= VS_STA && sy_n < VS_END) ? V_POL : ~V_POL;
      o_de    <= !sx_n[CORDW-1] && !sy_n[CORDW-1];
      o_line  <= (sx_n == H_STA);
      o_frame <= (sx_n == H_STA) && (sy_n == V_STA);
    end
  end

endmodule

// File: tb/tb_display_timings_gen.sv
// Randomized-reset scoreboard bench for display_timings_gen in three timing modes.
module tb_display_timings_gen;

  typedef struct packed {
    int hres, hfp, hsync, hbp, vres, vfp, vsync, vbp;
    bit hpol, vpol;
  } mode_t;

  typedef struct {
    logic hs, vs, de, frame, line;
    int   sx, sy;
  } exp_t;

  localparam mode_t M0 = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam mode_t M1 = '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1};
  localparam mode_t M2 = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic d0_hs, d0_vs, d0_de, d0_frame, d0_line;
  logic d1_hs, d1_vs, d1_de, d1_frame, d1_line;
  logic d2_hs, d2_vs, d2_de, d2_frame, d2_line;
  logic signed [15:0] d0_sx, d0_sy, d1_sx, d1_sy;
  logic signed [7:0]  d2_sx, d2_sy;

  display_timings_gen d0 (
    .i_clk(clk), .i_rst(rst), .o_hs(d0_hs), .o_vs(d0_vs), .o_de(d0_de),
    .o_frame(d0_frame), .o_line(d0_line), .o_sx(d0_sx), .o_sy(d0_sy)
  );

  display_timings_gen #(
    .CORDW(16), .H_RES(1280), .V_RES(720), .H_FP(110), .H_SYNC(40), .H_BP(220),
    .V_FP(5), .V_SYNC(5), .V_BP(20), .H_POL(1'b1), .V_POL(1'b1)
  ) d1 (
    .i_clk(clk), .i_rst(rst), .o_hs(d1_hs), .o_vs(d1_vs), .o_de(d1_de),
    .o_frame(d1_frame), .o_line(d1_line), .o_sx(d1_sx), .o_sy(d1_sy)
  );

  display_timings_gen #(
    .CORDW(8), .H_RES(8), .V_RES(4), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_FP(1), .V_SYNC(2), .V_BP(1), .H_POL(1'b0), .V_POL(1'b1)
  ) d2 (
    .i_clk(clk), .i_rst(rst), .o_hs(d2_hs), .o_vs(d2_vs), .o_de(d2_de),
    .o_frame(d2_frame), .o_line(d2_line), .o_sx(d2_sx), .o_sy(d2_sy)
  );

  int   total  = 0;
  int   passed = 0;
  exp_t q0[$], q1[$], q2[$];
  int   k = 0;

  // Position after k clock edges since reset release, from the blanking-offset view of a frame
  function automatic exp_t model(mode_t m, int kk);
    exp_t e;
    int htot = m.hres + m.hfp + m.hsync + m.hbp;
    int vtot = m.vres + m.vfp + m.vsync + m.vbp;
    int pos  = kk % (htot * vtot);
    int px   = pos % htot;
    int ly   = pos / htot;
    e.sx    = px - (m.hfp + m.hsync + m.hbp);
    e.sy    = ly - (m.vfp + m.vsync + m.vbp);
    e.hs    = (px >= m.hfp && px < m.hfp + m.hsync) ? m.hpol : ~m.hpol;
    e.vs    = (ly >= m.vfp && ly < m.vfp + m.vsync) ? m.vpol : ~m.vpol;
    e.de    = (e.sx >= 0) && (e.sy >= 0);
    e.line  = (kk > 0) && (px == 0);
    e.frame = (kk > 0) && (pos == 0);
    return e;
  endfunction

  task automatic push_all();
    q0.push_back(model(M0, k));
    q1.push_back(model(M1, k));
    q2.push_back(model(M2, k));
  endtask

  task automatic check(string nm, exp_t e, logic hs, logic vs, logic de, logic fr, logic ln,
                       logic signed [31:0] sx, logic signed [31:0] sy);
    total++;
    if ({hs, vs, de, fr, ln} !== {e.hs, e.vs, e.de, e.frame, e.line} || sx !== e.sx || sy !== e.sy)
      $display("FAIL %s t=%0t got hs=%b vs=%b de=%b fr=%b ln=%b sx=%0d sy=%0d want hs=%b vs=%b de=%b fr=%b ln=%b sx=%0d sy=%0d",
               nm, $time, hs, vs, de, fr, ln, sx, sy, e.hs, e.vs, e.de, e.frame, e.line, e.sx, e.sy);
    else passed++;
  endtask

  task automatic chk_eq(string nm, int got, int want);
    total++;
    if (got !== want) $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, got, want);
    else passed++;
  endtask

  int lcnt[2], hcnt[2];
  bit lseen[2];
  int fcnt, vcnt;
  bit fseen;

  // Line period and sync-width measured between consecutive line strobes
  task automatic track_line(int i, logic ln, logic hs_act, int per, int hw);
    if (ln) begin
      if (lseen[i]) begin
        chk_eq($sformatf("line_period%0d", i), lcnt[i], per);
        chk_eq($sformatf("hsync_width%0d", i), hcnt[i], hw);
      end
      lseen[i] = 1'b1;
      lcnt[i]  = 0;
      hcnt[i]  = 0;
    end
    lcnt[i] += 1;
    hcnt[i] += int'(hs_act);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin e = q0.pop_front(); check("m640", e, d0_hs, d0_vs, d0_de, d0_frame, d0_line, d0_sx, d0_sy); end
      if (q1.size() > 0) begin e = q1.pop_front(); check("m720", e, d1_hs, d1_vs, d1_de, d1_frame, d1_line, d1_sx, d1_sy); end
      if (q2.size() > 0) begin e = q2.pop_front(); check("msmall", e, d2_hs, d2_vs, d2_de, d2_frame, d2_line, d2_sx, d2_sy); end
      if (rst) begin
        lseen[0] = 1'b0;
        lseen[1] = 1'b0;
        fseen    = 1'b0;
      end else begin
        track_line(0, d0_line, d0_hs == 1'b0, 800, 96);
        track_line(1, d1_line, d1_hs == 1'b1, 1650, 40);
        if (d2_frame) begin
          if (fseen) begin
            chk_eq("frame_period_small", fcnt, 120);
            chk_eq("vsync_clocks_small", vcnt, 30);
          end
          fseen = 1'b1;
          fcnt  = 0;
          vcnt  = 0;
        end
        fcnt += 1;
        vcnt += int'(d2_vs == 1'b1);
      end
    end
  end

  initial begin : stimulus
    for (int s = 0; s < 5; s++) begin
      int hold = $urandom_range(1, 4);
      int run  = $urandom_range(3500, 6000);
      @(posedge clk);
      #2;
      rst = 1'b1;
      k   = 0;
      push_all();
      repeat (hold) begin
        @(posedge clk);
        #2;
        push_all();
      end
      @(posedge clk);
      #2;
      rst = 1'b0;
      push_all();
      repeat (run) begin
        @(posedge clk);
        k++;
        #2;
        push_all();
      end
    end
    @(negedge clk);
    #1;
    chk_eq("queues_drained", q0.size() + q1.size() + q2.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
